// File: rtl/tone_period_meter.sv
// tone_period_meter: measures half-period and period of an async square wave
// in inclk cycles; reports lock between consecutive halves and signal loss.
module tone_period_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'd50_000_000,
  parameter logic [31:0] TOL         = 32'd1
) (
  input  logic        inclk,
  input  logic        Reset,
  input  logic        sig_in,
  output logic [31:0] half_count,
  output logic [31:0] period_count,
  output logic        valid,
  output logic        locked,
  output logic        no_signal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_MEAS  = 2'd2;
  localparam logic [1:0] S_LOST  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_s;

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] prev_q, prev_d;
  logic        have_prev_q, have_prev_d;
  logic [31:0] half_q, half_d;
  logic [31:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        locked_q, locked_d;
  logic        nosig_q, nosig_d;

  logic [31:0] cur;
  logic [32:0] sum;
  logic [31:0] diff;
  logic        tmo;

  assign edge_s = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign cur    = cnt_q + 32'd1;
  assign sum    = {1'b0, cur} + {1'b0, prev_q};
  assign diff   = (cur >= prev_q) ? (cur - prev_q)
                                  : (prev_q - cur);
  assign tmo    = (cnt_q == TIMEOUT - 32'd1);

  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = edge_s ? 32'd0 : cnt_q + 32'd1;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    half_d      = half_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    nosig_d     = nosig_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (edge_s) state_d = S_ARMED;
      end
      (state_q == S_ARMED),
      (state_q == S_MEAS): begin
        if (edge_s) begin
          half_d      = cur;
          valid_d     = 1'b1;
          prev_d      = cur;
          have_prev_d = 1'b1;
          state_d     = S_MEAS;
          // period/lock need a previous half from this same run
          if (state_q == S_MEAS && have_prev_q) begin
            period_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
            locked_d = (diff <= TOL);
          end
        end else if (tmo) begin
          state_d  = S_LOST;
          nosig_d  = 1'b1;
          locked_d = 1'b0;
        end
      end
      default: begin
        if (edge_s) begin
          nosig_d     = 1'b0;
          have_prev_d = 1'b0;
          state_d     = S_ARMED;
        end
      end
    endcase
  end

  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      half_q      <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      nosig_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      half_q      <= half_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      nosig_q     <= nosig_d;
    end
  end

  assign half_count   = half_q;
  assign period_count = period_q;
  assign valid        = valid_q;
  assign locked       = locked_q;
  assign no_signal    = nosig_q;

endmodule

// File: doc/tone_period_meter.md
# tone_period_meter

Measures the half-period and full period of an externally generated square wave, such as a tone-divider output or an external tone source, in units of `inclk` cycles. The measured `half_count` equals the `div_clk_count` that would reproduce the same waveform from `inclk`, so the block is the inverse of the tone divider. It sits beside the tone organ datapath so that a generated or captured tone's frequency can be read back, checked for lock, and flagged when absent.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sig_in` (legal values 2..3).
- `TIMEOUT`, 32'd50_000_000: `inclk` cycles without an edge before `no_signal` asserts.
- `TOL`, 32'd1: maximum absolute difference between the last two half-periods for `locked`.
- `inclk`  in  1  system clock; all logic on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `sig_in`  in  1  square wave under measurement; asynchronous to `inclk`.
- `half_count`  out  32  last measured half-period, in `inclk` cycles.
- `period_count`  out  32  sum of the last two half-periods; saturates at 32'hFFFF_FFFF.
- `valid`  out  1  single-cycle pulse when `half_count` updates.
- `locked`  out  1  last two half-periods agree within `TOL`.
- `no_signal`  out  1  high while no edge has been seen for `TIMEOUT` cycles.

## Operation
- `sig_in` passes through `SYNC_STAGES` flops, then one history flop. `edge` = sync output XOR history. Both rising and falling edges count.
- `cnt` (32 bits) clears to 0 on an edge cycle and otherwise increments by 1. At the next edge it holds N−1, and the measured half-period is `cnt`+1 = N.
- FSM states:
  - IDLE: entered from reset. On the first edge go to ARMED, clear `cnt`, make no measurement.
  - ARMED: on an edge, set `half_count`=`cnt`+1, pulse `valid`, set `prev`=that value, set `have_prev`=1, and go to MEAS. If `cnt`==`TIMEOUT`−1 with no edge, go to LOST.
  - MEAS: on an edge, set `half_count`=`cnt`+1, set `period_count`=sat(`cnt`+1+`prev`), pulse `valid`, set `locked`=(|`cnt`+1−`prev`|≤`TOL`), then set `prev`=`cnt`+1. Timeout rule is the same as ARMED.
  - LOST: `no_signal`=1 and `locked`=0; `half_count`/`period_count` hold their last values. On an edge, set `no_signal`=0, clear `have_prev`, and go to ARMED without measuring.
- The `period_count` sum is computed 33 bits wide; if bit 32 is set, output 32'hFFFF_FFFF.
- `period_count` and `locked` update only from MEAS. The first measurement after IDLE or LOST leaves them unchanged.
- An edge takes priority over timeout in the same cycle.
- `Reset` low at any time, including mid-measurement:
  - all flops clear: sync chain 0, `cnt` 0, state IDLE;
  - all outputs 0.
- The sync chain resets to 0, so if `sig_in` is high at reset release, the resulting rising edge is taken as the IDLE arming edge.

## Timing
- An edge on `sig_in` (meeting setup) is reflected in the outputs at the (`SYNC_STAGES`+1)th `inclk` rising edge after it. That is 3 edges for the default.
- This latency is constant per edge, so measured counts are exact for clean input.
- `valid` is high for exactly one cycle, coincident with the new `half_count`/`period_count`/`locked` values.
- Minimum measurable half-period is 1 cycle (edges on consecutive cycles give `half_count`=1).
- `no_signal` asserts in the cycle after `cnt` reaches `TIMEOUT`−1, i.e. `TIMEOUT`+1 cycles after the last edge was registered.

## Test plan
- Square wave toggling every 5 `inclk` cycles from reset:
  - 1st edge: no `valid`.
  - 2nd edge: `valid`, `half_count`=5, `period_count`/`locked` still 0.
  - 3rd edge onward: `period_count`=10, `locked`=1.
- Half-periods alternating 100/101 with `TOL`=1 gives `locked`=1 and `period_count`=201. Alternating 100/103 gives `locked`=0.
- With `TIMEOUT`=20, hold `sig_in` after steady 5-cycle toggling:
  - `no_signal` rises 21 cycles after the last registered edge;
  - `locked` drops to 0 and `half_count` stays 5;
  - the next edge clears `no_signal` with no `valid`; the edge after that gives `valid`.
- Assert `Reset` mid-half-period while locked:
  - all outputs are 0 immediately, asynchronously;
  - after release, the first measurement needs two edges.
- A 1-cycle glitch pulse on `sig_in` gives `half_count`=1 and `locked`=0.
- Saturation: force `cnt`+1+`prev` beyond 2^32 (for example by preloading through a bench `force`) -> `period_count`=32'hFFFF_FFFF.
